dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, 14, word-address width of the shared data RAM.
REQ-002 Parameter DATA_W, 32, data width of the RAM and both ports.
REQ-003 Parameter STARVE_LIMIT, 8, cycles port 1 may wait before it is forced a grant.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 p0_req/p0_wren  in  1/1  CPU port: request and write-enable; p0_addr in 32 byte address; p0_wdata in DATA_W.
REQ-007 p1_req/p1_wren  in  1/1  device port (console/VGA): request and write-enable; p1_addr in ADDR_W word address; p1_wdata in DATA_W.
REQ-008 p0_gnt, p1_gnt  out  1  request accepted this cycle.
REQ-009 p0_rvalid, p1_rvalid  out  1  one-cycle completion pulse; p0_rdata, p1_rdata out DATA_W read data.
REQ-010 p0_err  out  1  one-cycle pulse: CPU address outside the data window.
REQ-011 mem_addr out ADDR_W, mem_wren out 1, mem_data out DATA_W, mem_q in DATA_W  RAM side; the RAM has 1-cycle registered read.
REQ-012 busy  out  1  high whenever state is not IDLE.

Function
REQ-013 States: IDLE, ACCESS, RESP.
REQ-014 Grant is evaluated combinationally in IDLE and RESP only; at most one gnt high per cycle.
REQ-015 Requester holds req, wren, addr, wdata stable until its gnt is sampled high; the arbiter latches them in the grant cycle.
REQ-016 Grant cycle N -> ACCESS in N+1 (mem_addr/mem_data/mem_wren driven from latch) -> RESP in N+2 (rvalid pulse to the granted port, rdata = mem_q for reads, unchanged for writes).
REQ-017 RESP with a new grant goes to ACCESS; otherwise to IDLE; sustained throughput is one access per 2 cycles.
REQ-018 mem_wren is high only in ACCESS with latched wren=1; mem_addr/mem_data hold last value otherwise.
REQ-019 CPU translation: word index = (p0_addr - DMEM_BASE) >> 2, truncated to ADDR_W bits.
REQ-020 p0_addr < DMEM_BASE or >= DMEM_BASE + 4*2^ADDR_W: gnt still given, no RAM write, RESP pulses p0_rvalid with p0_rdata = 0 and p0_err = 1.
REQ-021 Default policy: fixed priority, port 0 wins.
REQ-022 Starvation counter increments each cycle p1_req is high and p1_gnt low, clears on p1_gnt; at count = STARVE_LIMIT port 1 wins the next grant opportunity.
REQ-023 rdata outputs hold their value between rvalid pulses.

Reset
REQ-024 On rst: state IDLE; all gnt, rvalid, err, mem_wren, busy = 0; rdata, mem_addr, mem_data = 0; starvation counter = 0; round-robin pointer = port 0.
REQ-025 Reset mid-ACCESS aborts the access immediately; no rvalid is issued for it.

Configuration
REQ-026 Macro DMEM_ARB_ROUND_ROBIN_EN defined: round-robin; last-granted port has lowest priority on simultaneous requests; starvation counter is not built.
REQ-027 Undefined: fixed priority plus starvation counter per REQ-021/022.

Structure
REQ-028 Package dmem_pkg holds DMEM_BASE = 32'h1000_0000, the state enum type, and the port-index constants.
REQ-029 One sub-module dmem_addr_xlate: combinational CPU address translation and range check.

Verification
REQ-030 Single read: p0 reads 0x10000008 with RAM word 2 = 0xDEADBEEF -> p0_gnt at N, mem_addr = 2 at N+1, p0_rvalid and p0_rdata = 0xDEADBEEF at N+2.
REQ-031 Write then read: p1 writes 0x12345678 to word 5, then p0 reads 0x10000014 -> p0_rdata = 0x12345678.
REQ-032 Simultaneous requests, fixed priority, p0 requesting every cycle -> p1_gnt exactly after 8 waiting cycles; with DMEM_ARB_ROUND_ROBIN_EN grants alternate p0, p1, p0, ...
REQ-033 Out of range: p0 reads 0x0FFFFFFC -> p0_err and p0_rvalid pulse at N+2, p0_rdata = 0, mem_wren never asserted.
REQ-034 rst asserted during ACCESS of a write -> mem_wren drops asynchronously, no rvalid, busy = 0, next request serviced normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: RAM window base,
// FSM state type and requester port indices.
package dmem_pkg;

  localparam logic [31:0] DMEM_BASE = 32'h1000_0000;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dmem_addr_xlate.sv
// CPU byte address -> RAM word index, plus window range check.
// The word index is truncated to ADDR_W bits; out-of-range addresses are
// flagged so the arbiter can suppress the RAM write and report an error.
module dmem_addr_xlate
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic [31:0]       byte_addr_i,
  output logic [ADDR_W-1:0] word_addr_o,
  output logic              out_of_range_o
);

  localparam logic [32:0] DMEM_TOP = {1'b0, DMEM_BASE} + (33'd4 << ADDR_W);

  assign word_addr_o    = ADDR_W'((byte_addr_i - DMEM_BASE) >> 2);
  assign out_of_range_o = (byte_addr_i < DMEM_BASE) ||
                          ({1'b0, byte_addr_i} >= DMEM_TOP);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM with 1-cycle read.
// Port 0 is the CPU (byte addresses, translated into the RAM window),
// port 1 is a device port (word addresses). One access every 2 cycles:
// grant (IDLE/RESP) -> ACCESS (RAM driven) -> RESP (completion pulse).
// Default policy: port 0 wins, with a starvation counter that forces a
// port 1 grant after STARVE_LIMIT waiting cycles.
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (last-granted port loses ties; no starvation counter).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              sel_q;
  logic              wren_q;
  logic              err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_wren_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
  logic [ADDR_W-1:0] p0_word;
  logic              p0_oor;
  logic              p1_prio;

  dmem_addr_xlate #(.ADDR_W(ADDR_W)) u_xlate (
    .byte_addr_i    (p0_addr),
    .word_addr_o    (p0_word),
    .out_of_range_o (p0_oor)
  );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic rr_q;

  assign p1_prio = (rr_q == PORT1);

  // Priority pointer: the port not granted last gets the tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= PORT0;
    end else if (p0_gnt) begin
      rr_q <= PORT1;
    end else if (p1_gnt) begin
      rr_q <= PORT0;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign p1_prio = (starve_q == CNT_W'(STARVE_LIMIT));

  // Count port 1 waiting cycles, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (p1_gnt) begin
      starve_d = '0;
    end else if (p1_req && !p1_prio) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Next state and grant decision; grants only in IDLE and RESP.
  always_comb begin
    state_d = state_q;
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (p1_req && (p1_prio || !p0_req)) begin
          p1_gnt  = 1'b1;
          state_d = ST_ACCESS;
        end else if (p0_req) begin
          p0_gnt  = 1'b1;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the granted request; it drives the RAM during ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= PORT0;
      wren_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
    end else begin
      mem_wren_q <= 1'b0;
      if (p0_gnt) begin
        sel_q      <= PORT0;
        wren_q     <= p0_wren;
        err_q      <= p0_oor;
        mem_addr_q <= p0_word;
        mem_data_q <= p0_wdata;
        mem_wren_q <= p0_wren && !p0_oor;
      end else if (p1_gnt) begin
        sel_q      <= PORT1;
        wren_q     <= p1_wren;
        err_q      <= 1'b0;
        mem_addr_q <= p1_addr;
        mem_data_q <= p1_wdata;
        mem_wren_q <= p1_wren;
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_wren  = mem_wren_q;
  assign busy      = (state_q != ST_IDLE);

  assign p0_rvalid = (state_q == ST_RESP) && (sel_q == PORT0);
  assign p1_rvalid = (state_q == ST_RESP) && (sel_q == PORT1);
  assign p0_err    = p0_rvalid && err_q;

  // RAM data is live only in RESP, so it is passed straight through there
  // and captured so the outputs hold until the next completion.
  assign p0_rdata = !p0_rvalid ? p0_rdata_q :
                    err_q      ? '0 :
                    wren_q     ? p0_rdata_q : mem_q;
  assign p1_rdata = (p1_rvalid && !wren_q) ? mem_q : p1_rdata_q;

  // Read-data hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      p0_rdata_q <= p0_rdata;
      p1_rdata_q <= p1_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, compared every cycle against a transaction-level model.
module tb_dmem_arbiter;

  localparam int          ADDR_W       = 14;
  localparam int          DATA_W       = 32;
  localparam int          STARVE_LIMIT = 8;
  localparam int          DEPTH        = 1 << ADDR_W;
  localparam logic [31:0] BASE         = 32'h1000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              p0_req, p0_wren, p0_gnt, p0_rvalid, p0_err;
  logic [31:0]       p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_wren, p1_gnt, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_data, mem_q;
  logic              busy;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wren(p0_wren), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_wren(p1_wren), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM with registered read.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'hDEAD_BEEF;
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  int                since;      // cycles since last grant (1 = access, 2 = response, 3 = idle)
  int                wait1;      // consecutive cycles port 1 has waited
  logic              rr_pri;     // port favoured on a tie (round-robin build)
  logic              pend_port, pend_wren, pend_err;
  int                pend_word;
  logic [DATA_W-1:0] pend_data, pend_rd;
  logic [DATA_W-1:0] rd_exp0, rd_exp1;
  logic              obs_g0, obs_g1;

  task automatic model_reset();
    since   = 3;
    wait1   = 0;
    rr_pri  = 1'b0;
    rd_exp0 = '0;
    rd_exp1 = '0;
  endtask

  function automatic void xlate(input logic [31:0] a, output int word, output logic oor);
    longint off;
    off  = longint'({32'h0, a}) - longint'({32'h0, BASE});
    oor  = (off < 0) || (off >= 4 * longint'(DEPTH));
    word = int'((off >>> 2) & longint'(DEPTH - 1));
  endfunction

  task automatic model_cycle();
    logic e_g0, e_g1, ev0, ev1, e_wr, prio, oor;
    int   w;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    prio = rr_pri;
`else
    prio = (wait1 >= STARVE_LIMIT);
`endif
    if (since != 1) begin
      if (p1_req && (!p0_req || prio)) e_g1 = 1'b1;
      else if (p0_req)                 e_g0 = 1'b1;
    end
    ev0  = (since == 2) && (pend_port == 1'b0);
    ev1  = (since == 2) && (pend_port == 1'b1);
    if (ev0) begin
      if (pend_err)        rd_exp0 = '0;
      else if (!pend_wren) rd_exp0 = pend_rd;
    end
    if (ev1 && !pend_wren) rd_exp1 = pend_rd;
    e_wr = (since == 1) && pend_wren && !pend_err;

    check_val("p0_gnt", p0_gnt, e_g0);
    check_val("p1_gnt", p1_gnt, e_g1);
    check_val("busy", busy, (since == 1) || (since == 2));
    check_val("p0_rvalid", p0_rvalid, ev0);
    check_val("p1_rvalid", p1_rvalid, ev1);
    check_val("p0_err", p0_err, ev0 && pend_err);
    check_val("p0_rdata", p0_rdata, rd_exp0);
    check_val("p1_rdata", p1_rdata, rd_exp1);
    check_val("mem_wren", mem_wren, e_wr);
    if (since == 1 && !pend_err) check_val("mem_addr", mem_addr, pend_word);
    if (e_wr) check_val("mem_data", mem_data, pend_data);

    obs_g0 = p0_gnt;
    obs_g1 = p1_gnt;

    if (e_wr) mdl_mem[pend_word] = pend_data;
    if (e_g0) begin
      xlate(p0_addr, w, oor);
      pend_port = 1'b0; pend_wren = p0_wren; pend_err = oor;
      pend_word = w;    pend_data = p0_wdata; pend_rd = mdl_mem[w];
      rr_pri    = 1'b1;
    end else if (e_g1) begin
      pend_port = 1'b1; pend_wren = p1_wren; pend_err = 1'b0;
      pend_word = int'(p1_addr); pend_data = p1_wdata; pend_rd = mdl_mem[int'(p1_addr)];
      rr_pri    = 1'b0;
    end
    if (e_g1)        wait1 = 0;
    else if (p1_req) wait1++;
    since = (e_g0 || e_g1) ? 1 : ((since < 3) ? since + 1 : 3);
  endtask

  // One clock: check at the falling edge, then requesters drop granted requests.
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (obs_g0) p0_req = 1'b0;
    if (obs_g1) p1_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (p0_req || p1_req || busy); i++) step();
    check_val("drain", {p0_req, p1_req, busy}, 3'b000);
  endtask

  task automatic set_p0(input logic wr, input logic [31:0] a, input logic [31:0] d);
    p0_req = 1'b1; p0_wren = wr; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set_p1(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    p1_req = 1'b1; p1_wren = wr; p1_addr = a; p1_wdata = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, seq_n;
    logic seq [8];
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = init_word(i);
      mdl_mem[i] = init_word(i);
    end
    pend_port = 1'b0; pend_wren = 1'b0; pend_err = 1'b0;
    pend_word = 0; pend_data = '0; pend_rd = '0;
    p0_req = 0; p0_wren = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_wren = 0; p1_addr = '0; p1_wdata = '0;
    rst = 1'b1;
    model_reset();
    #3;
    check_val("rst_busy", busy, 0);
    check_val("rst_mem_wren", mem_wren, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_data", mem_data, 0);
    check_val("rst_p0_rdata", p0_rdata, 0);
    check_val("rst_p1_rdata", p1_rdata, 0);
    check_val("rst_rvalid", {p0_rvalid, p1_rvalid, p0_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single read of word 2.
    set_p0(1'b0, 32'h1000_0008, 32'h0);
    step();
    check_val("rd_gnt_n", obs_g0, 1);
    check_val("rd_maddr_n1", mem_addr, 2);
    step();
    check_val("rd_rvalid_n2", p0_rvalid, 1);
    check_val("rd_rdata_n2", p0_rdata, 32'hDEAD_BEEF);
    drain();

    // Device write, then CPU read of the same word.
    set_p1(1'b1, 14'd5, 32'h1234_5678);
    drain();
    set_p0(1'b0, 32'h1000_0014, 32'h0);
    drain();
    check_val("wr_rd_rdata", p0_rdata, 32'h1234_5678);

    // Out-of-range CPU write just below the window.
    set_p0(1'b1, 32'h0FFF_FFFC, 32'h5555_AAAA);
    step();
    check_val("oor_mem_wren", mem_wren, 0);
    step();
    check_val("oor_err", {p0_err, p0_rvalid}, 2'b11);
    check_val("oor_rdata", p0_rdata, 0);
    drain();
    check_val("oor_ram_untouched", ram[14'h3FFF], init_word(14'h3FFF));

    // Simultaneous requests, port 0 asking every cycle.
    set_p1(1'b0, 14'd3, 32'h0);
    k = -1;
    seq_n = 0;
    for (int c = 0; c < 40 && seq_n < 8; c++) begin
      if (!p0_req) set_p0(1'b0, BASE + 32'(4 * (c % 16)), 32'h0);
      step();
      if (obs_g0 || obs_g1) begin
        seq[seq_n] = obs_g1;
        seq_n++;
      end
      if (obs_g1 && k < 0) k = c;
      if (k >= 0 && !p1_req) set_p1(1'b0, 14'd4, 32'h0);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    check_val("rr_first", k, 0);
    for (int i = 1; i < 8; i++) check_val("rr_alternate", seq[i], !seq[i-1]);
`else
    check_val("starve_wait", k, STARVE_LIMIT);
`endif
    drain();

    // Reset during the ACCESS cycle of a write.
    set_p1(1'b1, 14'd7, 32'hCAFE_F00D);
    step();
    check_val("rstmid_wren_before", mem_wren, 1);
    rst = 1'b1;
    #1;
    check_val("rstmid_wren_after", mem_wren, 0);
    check_val("rstmid_busy", busy, 0);
    @(negedge clk);
    check_val("rstmid_no_rvalid", p1_rvalid, 0);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    set_p0(1'b0, 32'h1000_001C, 32'h0);
    drain();
    check_val("rstmid_next_read", p0_rdata, init_word(7));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (!p0_req && $urandom_range(0, 9) < 6) begin
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 7);
        if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
        else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        else             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        set_p0(1'($urandom_range(0, 1)), a, $urandom);
      end
      if (!p1_req && $urandom_range(0, 9) < 5)
        set_p1(1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)), $urandom);
      step();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
